// File: rtl/lsu_load_unit.sv
// lsu_load_unit: accepts one load, issues one or two aligned bus reads, merges the bytes and sign/zero extends them.
module lsu_load_unit #(
  parameter int XLEN       = 32,
  parameter bit MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  input  logic [2:0]      func3,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] data_out,
  output logic            misaligned_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int SW = $clog2(XLEN);
  localparam logic [1:0] FULL_LG = 2'(OW);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   base_q, beat0_q, data_q, data_d;
  logic [XLEN-1:0]   lo, hi, raw, mask, merged;
  logic [2*XLEN-1:0] cat;
  logic [OW-1:0]     off_q;
  logic [1:0]        lg_q, lg_in;
  logic [SW-1:0]     sidx;
  logic              uns_q, cross_q, err_q, err_d;
  logic              full_in, cross_in, sign;

  // Codes with no legal meaning at this width fall back to the full-word load.
  assign full_in  = func3 == 3'b111 || (XLEN == 32 && (func3[1:0] == 2'b11 || func3 == 3'b110));
  assign lg_in    = full_in ? FULL_LG : func3[1:0];
  assign cross_in = int'(req_addr[OW-1:0]) + (1 << lg_in) > NB;

  // Beat 1 only exists in WAIT1; a single-beat access merges against zeros.
  assign lo     = state_q == WAIT1 ? beat0_q : mem_rdata;
  assign hi     = state_q == WAIT1 ? mem_rdata : '0;
  assign cat    = {hi, lo} >> {off_q, 3'b000};
  assign raw    = cat[XLEN-1:0];
  assign mask   = (XLEN'(1) << (8 << lg_q)) - XLEN'(1);
  assign sidx   = SW'((8 << lg_q) - 1);
  assign sign   = ~uns_q & raw[sidx];
  assign merged = (raw & mask) | ({XLEN{sign}} & ~mask);

  assign req_ready      = state_q == IDLE;
  assign mem_req        = state_q == REQ0 || state_q == REQ1;
  assign mem_addr       = state_q == REQ1 ? base_q + XLEN'(NB) : (state_q == REQ0 ? base_q : '0);
  assign resp_valid     = state_q == RESP;
  assign data_out       = data_q;
  assign misaligned_err = err_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (cross_in && !MISALIGNED) begin
          state_d = RESP;
          data_d  = '0;
          err_d   = 1'b1;
        end else state_d = REQ0;
      end
      REQ0: if (mem_gnt) state_d = WAIT0;
      WAIT0: if (mem_rvalid) begin
        if (cross_q) state_d = REQ1;
        else begin
          state_d = RESP;
          data_d  = merged;
          err_d   = 1'b0;
        end
      end
      REQ1: if (mem_gnt) state_d = WAIT1;
      WAIT1: if (mem_rvalid) begin
        state_d = RESP;
        data_d  = merged;
        err_d   = 1'b0;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      err_q   <= 1'b0;
      base_q  <= '0;
      beat0_q <= '0;
      off_q   <= '0;
      lg_q    <= '0;
      uns_q   <= 1'b0;
      cross_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (req_valid && req_ready) begin
        base_q  <= req_addr & ~XLEN'(NB - 1);
        off_q   <= req_addr[OW-1:0];
        lg_q    <= lg_in;
        uns_q   <= func3[2];
        cross_q <= cross_in;
      end
      if (state_q == WAIT0 && mem_rvalid) beat0_q <= mem_rdata;
    end
  end
endmodule
